// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory arbiter: FSM states, port ids, byte-lane count.
package mem_arb_pkg;
   localparam int LANES = 4;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;
endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-request round-robin picker; on a tie the port that did not win last time goes.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_port
);
   always_comb begin
      grant_valid = |req;
      grant_port  = PORT_I;
      case (req)
         2'b01:   grant_port = PORT_I;
         2'b10:   grant_port = PORT_D;
         2'b11:   grant_port = ~last_grant;
         default: grant_port = PORT_I;
      endcase
   end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between icache and dcache: round-robin grant,
// fixed-latency access, then a one-cycle stop pulse to the winner.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LATENCY = 4,
   parameter int CNT_W       = $clog2(MEM_LATENCY + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_interupt_start,
   input  logic [31:0]             i_mem_addr,
   input  logic                    i_mem_we,
   input  logic [0:LANES-1][7:0]   i_mem_data_in,
   output logic [0:LANES-1][7:0]   i_mem_data_out,
   output logic                    i_interupt_stop,
   input  logic                    d_interupt_start,
   input  logic [31:0]             d_mem_addr,
   input  logic                    d_mem_we,
   input  logic [0:LANES-1][7:0]   d_mem_data_in,
   output logic [0:LANES-1][7:0]   d_mem_data_out,
   output logic                    d_interupt_stop,
   output logic [31:0]             mem_addr,
   output logic                    mem_we,
   output logic [0:LANES-1][7:0]   mem_data_in,
   input  logic [0:LANES-1][7:0]   mem_data_out
);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   state_t           state, state_nxt;
   port_t            grant, last_grant;
   logic [CNT_W-1:0] cnt;
   logic             pick_valid;
   logic             pick_raw;
   port_t            pick;

   rr_arbiter2 u_rr (
      .req         ({d_interupt_start, i_interupt_start}),
      .last_grant  (last_grant),
      .grant_valid (pick_valid),
      .grant_port  (pick_raw)
   );
   assign pick = port_t'(pick_raw);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid) state_nxt = ACCESS;
         ACCESS:  if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Requests are only sampled in IDLE, so a late or changing request waits untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant          <= PORT_I;
         last_grant     <= PORT_D;
         cnt            <= '0;
         mem_addr       <= '0;
         mem_we         <= 1'b0;
         mem_data_in    <= '0;
         i_mem_data_out <= '0;
         d_mem_data_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               mem_we <= 1'b0;
               if (pick_valid) begin
                  grant      <= pick;
                  last_grant <= pick;
                  cnt        <= CNT_LOAD;
                  if (pick == PORT_I) begin
                     mem_addr    <= i_mem_addr;
                     mem_we      <= i_mem_we;
                     mem_data_in <= i_mem_data_in;
                  end else begin
                     mem_addr    <= d_mem_addr;
                     mem_we      <= d_mem_we;
                     mem_data_in <= d_mem_data_in;
                  end
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  mem_we <= 1'b0;
                  if (!mem_we) begin
                     if (grant == PORT_I) i_mem_data_out <= mem_data_out;
                     else                 d_mem_data_out <= mem_data_out;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign i_interupt_stop = (state == DONE) && (grant == PORT_I);
   assign d_interupt_stop = (state == DONE) && (grant == PORT_D);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on a MEM_LATENCY=4 and a MEM_LATENCY=1 build,
// then random traffic against a transaction-level reference model.
module tb_mem_arbiter;
   typedef logic [0:3][7:0] word_t;
   localparam int L = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_start = 0, d_start = 0, i_we = 0, d_we = 0;
   logic [31:0] i_addr = 0, d_addr = 0;
   word_t       i_din = 0, d_din = 0, mem_dout = 0;
   word_t       i_dout, d_dout, mem_din;
   logic        i_stop, d_stop, mem_we;
   logic [31:0] mem_addr;

   logic        b_i_start = 0, b_i_we = 0;
   logic [31:0] b_i_addr = 0;
   word_t       b_mem_dout = 0;
   word_t       b_i_dout, b_d_dout, b_mem_din;
   logic        b_i_stop, b_d_stop, b_mem_we;
   logic [31:0] b_mem_addr;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.MEM_LATENCY(L)) dut (
      .clk(clk), .reset(reset),
      .i_interupt_start(i_start), .i_mem_addr(i_addr), .i_mem_we(i_we),
      .i_mem_data_in(i_din), .i_mem_data_out(i_dout), .i_interupt_stop(i_stop),
      .d_interupt_start(d_start), .d_mem_addr(d_addr), .d_mem_we(d_we),
      .d_mem_data_in(d_din), .d_mem_data_out(d_dout), .d_interupt_stop(d_stop),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_data_in(mem_din), .mem_data_out(mem_dout)
   );

   mem_arbiter #(.MEM_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset),
      .i_interupt_start(b_i_start), .i_mem_addr(b_i_addr), .i_mem_we(b_i_we),
      .i_mem_data_in(32'h0), .i_mem_data_out(b_i_dout), .i_interupt_stop(b_i_stop),
      .d_interupt_start(1'b0), .d_mem_addr(32'h0), .d_mem_we(1'b0),
      .d_mem_data_in(32'h0), .d_mem_data_out(b_d_dout), .d_interupt_stop(b_d_stop),
      .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_data_in(b_mem_din),
      .mem_data_out(b_mem_dout)
   );

   task automatic do_reset;
      @(negedge clk);
      reset = 1; i_start = 0; d_start = 0; b_i_start = 0;
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset;
      reset = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({i_stop, d_stop, mem_we, mem_addr, mem_din, i_dout, d_dout} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got stop=%b%b we=%b addr=%h din=%h iout=%h dout=%h, want all 0",
                  i_stop, d_stop, mem_we, mem_addr, mem_din, i_dout, d_dout);
      end
      n_cmp++;
      if ({b_i_stop, b_d_stop, b_mem_we, b_mem_addr, b_i_dout} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs_lat1: got stop=%b we=%b addr=%h, want 0", b_i_stop, b_mem_we, b_mem_addr);
      end
      reset = 0;
   endtask

   task automatic test_single_read;
      int    stop_cyc = 0, stop_n = 0, dstop_n = 0, addr_bad = 0;
      word_t w = {8'h11, 8'h22, 8'h33, 8'h44};
      @(negedge clk);
      i_addr = 32'h0000_0040; i_we = 0; i_start = 1; mem_dout = w;
      for (int c = 1; c <= L + 2; c++) begin
         @(negedge clk);
         if (c <= L && (mem_addr !== 32'h40 || mem_we !== 1'b0)) addr_bad++;
         if (i_stop) begin stop_n++; if (stop_cyc == 0) stop_cyc = c; i_start = 0; end
         if (d_stop) dstop_n++;
      end
      n_cmp++;
      if (addr_bad !== 0) begin n_bad++; $display("FAIL read_addr: %0d bad cycles, want 0", addr_bad); end
      n_cmp++;
      if (stop_cyc !== L + 1) begin n_bad++; $display("FAIL read_stop_cycle: got %0d want %0d", stop_cyc, L + 1); end
      n_cmp++;
      if (stop_n !== 1) begin n_bad++; $display("FAIL read_stop_width: got %0d want 1", stop_n); end
      n_cmp++;
      if (dstop_n !== 0) begin n_bad++; $display("FAIL read_dstop: got %0d pulses want 0", dstop_n); end
      n_cmp++;
      if (i_dout !== w) begin n_bad++; $display("FAIL read_data: got %h want %h", i_dout, w); end
   endtask

   task automatic test_write;
      int    we_n = 0, bad = 0, stop_cyc = 0, stop_n = 0, istop_n = 0;
      word_t w = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
      @(negedge clk);
      d_addr = 32'h0000_1000; d_we = 1; d_din = w; d_start = 1; mem_dout = 32'h5555_5555;
      for (int c = 1; c <= L + 3; c++) begin
         @(negedge clk);
         if (mem_we) begin
            we_n++;
            if (mem_din !== w || mem_addr !== 32'h1000 || c > L) bad++;
         end
         if (d_stop) begin stop_n++; if (stop_cyc == 0) stop_cyc = c; d_start = 0; end
         if (i_stop) istop_n++;
      end
      d_we = 0;
      n_cmp++;
      if (we_n !== L) begin n_bad++; $display("FAIL write_we_cycles: got %0d want %0d", we_n, L); end
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL write_bus: %0d bad cycles want 0", bad); end
      n_cmp++;
      if (stop_cyc !== L + 1 || stop_n !== 1) begin
         n_bad++; $display("FAIL write_stop: got cycle %0d x%0d want cycle %0d x1", stop_cyc, stop_n, L + 1);
      end
      n_cmp++;
      if (istop_n !== 0) begin n_bad++; $display("FAIL write_istop: got %0d want 0", istop_n); end
      n_cmp++;
      if (d_dout !== 32'h0) begin n_bad++; $display("FAIL write_dout_kept: got %h want 0", d_dout); end
   endtask

   task automatic test_simultaneous;
      int ev_port[$];
      int ev_cyc[$];
      do_reset();
      i_addr = 32'h100; d_addr = 32'h200; i_we = 0; d_we = 0;
      i_start = 1; d_start = 1;
      for (int c = 1; c <= 4 * (L + 2); c++) begin
         @(negedge clk);
         if (i_stop) begin ev_port.push_back(0); ev_cyc.push_back(c); i_start = 0; end
         else if (!i_start) i_start = 1;
         if (d_stop) begin ev_port.push_back(1); ev_cyc.push_back(c); d_start = 0; end
         else if (!d_start) d_start = 1;
      end
      i_start = 0; d_start = 0;
      repeat (L + 4) @(negedge clk);
      n_cmp++;
      if (ev_cyc.size() !== 4) begin n_bad++; $display("FAIL sim_event_count: got %0d want 4", ev_cyc.size()); end
      for (int n = 0; n < ev_cyc.size() && n < 4; n++) begin
         n_cmp++;
         if (ev_port[n] !== n % 2 || ev_cyc[n] !== (L + 1) + n * (L + 2)) begin
            n_bad++;
            $display("FAIL sim_grant%0d: got port %0d cycle %0d want port %0d cycle %0d",
                     n, ev_port[n], ev_cyc[n], n % 2, (L + 1) + n * (L + 2));
         end
      end
   endtask

   task automatic test_late_arrival;
      int i_sc = 0, d_sc = 0;
      @(negedge clk);
      i_addr = 32'h300; i_we = 0; i_start = 1;
      for (int c = 1; c <= 2 * L + 4; c++) begin
         @(negedge clk);
         if (c == L) begin
            n_cmp++;
            if (mem_addr !== 32'h300) begin n_bad++; $display("FAIL late_i_held: got %h want 300", mem_addr); end
         end
         if (c == L + 3) begin
            n_cmp++;
            if (mem_addr !== 32'hA2) begin n_bad++; $display("FAIL late_addr_at_grant: got %h want a2", mem_addr); end
            d_addr = 32'hA3;
         end
         if (c == L + 4) begin
            n_cmp++;
            if (mem_addr !== 32'hA2) begin n_bad++; $display("FAIL late_addr_stable: got %h want a2", mem_addr); end
         end
         if (i_stop) begin if (i_sc == 0) i_sc = c; i_start = 0; end
         if (d_stop) begin if (d_sc == 0) d_sc = c; d_start = 0; end
         if (c == 2) begin d_start = 1; d_we = 0; d_addr = 32'hA1; end
         if (c == 3) d_addr = 32'hA2;
      end
      n_cmp++;
      if (i_sc !== L + 1 || d_sc !== 2 * L + 3) begin
         n_bad++; $display("FAIL late_stops: got i=%0d d=%0d want i=%0d d=%0d", i_sc, d_sc, L + 1, 2 * L + 3);
      end
   endtask

   task automatic test_reset_mid;
      int i_sc = 0, d_sc = 0;
      @(negedge clk);
      d_addr = 32'h2000; d_we = 1; d_din = 32'hCAFE_F00D; d_start = 1;
      @(negedge clk);
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      n_cmp++;
      if ({i_stop, d_stop, mem_we} !== 3'b000 || mem_addr !== 32'h0) begin
         n_bad++; $display("FAIL reset_mid: got stop=%b%b we=%b addr=%h want 0", i_stop, d_stop, mem_we, mem_addr);
      end
      reset = 0; i_addr = 32'h400; i_we = 0; i_start = 1;
      for (int c = 1; c <= 2 * L + 4; c++) begin
         @(negedge clk);
         if (i_stop) begin if (i_sc == 0) i_sc = c; i_start = 0; end
         if (d_stop) begin if (d_sc == 0) d_sc = c; d_start = 0; end
      end
      d_we = 0;
      n_cmp++;
      if (i_sc !== L + 1 || d_sc !== 2 * L + 3) begin
         n_bad++; $display("FAIL reset_mid_resume: got i=%0d d=%0d want i=%0d d=%0d", i_sc, d_sc, L + 1, 2 * L + 3);
      end
   endtask

   task automatic test_lat1;
      int    s1 = 0, s2 = 0, n = 0, we_n = 0;
      word_t w = word_t'($urandom);
      @(negedge clk);
      b_i_addr = 32'h44; b_i_we = 0; b_mem_dout = w; b_i_start = 1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (b_mem_we) we_n++;
         if (b_i_stop) begin
            n++;
            if (n == 1) s1 = c; else if (n == 2) s2 = c;
            b_i_start = 0;
         end else if (!b_i_start && n == 1) b_i_start = 1;
      end
      n_cmp++;
      if (s1 !== 2 || s2 !== 5 || n !== 2) begin
         n_bad++; $display("FAIL lat1_stops: got %0d,%0d (n=%0d) want 2,5 (n=2)", s1, s2, n);
      end
      n_cmp++;
      if (b_i_dout !== w || we_n !== 0) begin
         n_bad++; $display("FAIL lat1_read: got data %h we_cycles %0d want %h 0", b_i_dout, we_n, w);
      end
   endtask

   // Reference: a transaction owns the port for L+1 cycles after the grant edge;
   // the last of those is the stop cycle, and read data is whatever memory showed just before it.
   task automatic test_random;
      int          rem = 0;
      bit          last = 1, own = 0, lat_we = 0;
      logic [31:0] lat_addr = 0;
      word_t       lat_din = 0;
      word_t       exp_out[2];
      logic [130:0] got, want;
      exp_out[0] = 0; exp_out[1] = 0;
      do_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(negedge clk);
         want = {rem == 1 && !own, rem == 1 && own, rem >= 2 && lat_we, lat_addr, lat_din, exp_out[0], exp_out[1]};
         got  = {i_stop, d_stop, mem_we, mem_addr, mem_din, i_dout, d_dout};
         n_cmp++;
         if (got !== want) begin
            n_bad++; $display("FAIL random cyc %0d: got %h want %h", cyc, got, want);
         end
         if (i_stop) i_start = 0;
         else if (!i_start && $urandom_range(2) == 0) i_start = 1;
         if (d_stop) d_start = 0;
         else if (!d_start && $urandom_range(2) == 0) d_start = 1;
         i_addr = $urandom; i_we = 1'($urandom); i_din = word_t'($urandom);
         d_addr = $urandom; d_we = 1'($urandom); d_din = word_t'($urandom);
         mem_dout = word_t'($urandom);
         @(posedge clk);
         if (rem == 0) begin
            if (i_start || d_start) begin
               own  = (i_start && d_start) ? !last : d_start;
               last = own;
               lat_addr = own ? d_addr : i_addr;
               lat_we   = own ? d_we   : i_we;
               lat_din  = own ? d_din  : i_din;
               rem = L + 1;
            end
         end else begin
            if (rem == 2 && !lat_we) exp_out[own] = mem_dout;
            rem--;
         end
      end
      i_start = 0; d_start = 0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_simultaneous();
      test_late_arrival();
      test_reset_mid();
      test_lat1();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single main-memory port shared by the instruction cache and the data cache. Each cache raises its `interupt_start` miss/write-through request and holds it. The arbiter grants one request at a time in round-robin order. It drives the memory for a fixed `MEM_LATENCY`, then returns read data and a one-cycle `interupt_stop` to the winner. It sits between both `Cache` instances and the memory model in the processor top level.

## Interface
- `MEM_LATENCY`, default 4: memory access cycles per transaction, ≥1.
- `CNT_W`, default `$clog2(MEM_LATENCY+1)`: width of the latency counter.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `i_interupt_start`  in  1  icache request, held until `i_interupt_stop`
- `i_mem_addr`  in  32  icache request address
- `i_mem_we`  in  1  icache write request (1 = write)
- `i_mem_data_in`  in  8×[0:3]  icache write bytes
- `i_mem_data_out`  out  8×[0:3]  read bytes returned to the icache
- `i_interupt_stop`  out  1  one-cycle completion pulse to the icache
- `d_*`: the same six signals for the dcache
- `mem_addr`  out  32  address to memory
- `mem_we`  out  1  memory write enable
- `mem_data_in`  out  8×[0:3]  write bytes to memory
- `mem_data_out`  in  8×[0:3]  read bytes from memory

## Operation
- **FSM states:** IDLE, ACCESS, DONE.
- **Reset values:**
  - FSM state = IDLE; counter = 0.
  - `last_grant` = D, so the icache wins the first tie.
  - All outputs = 0, including both stops, `mem_we`, `mem_addr`, `mem_data_in`, and both `*_mem_data_out`.
- **IDLE:**
  - No start asserted: stay in IDLE; `mem_we` = 0.
  - Exactly one start asserted: grant that port.
  - Both starts asserted: grant the port ≠ `last_grant`.
  - On grant:
    - latch the granted port's addr, we and data into `mem_addr`, `mem_we` and `mem_data_in`;
    - set `grant` and `last_grant`;
    - set counter = `MEM_LATENCY`-1;
    - go to ACCESS.
- **ACCESS:**
  - Memory outputs stay stable.
  - Counter decrements each cycle.
  - When counter = 0:
    - a read captures `mem_data_out` into the granted port's `*_mem_data_out`;
    - `mem_we` is set to 0;
    - go to DONE.
  - A write leaves `*_mem_data_out` unchanged.
- **DONE:**
  - The granted port's `*_interupt_stop` = 1 for exactly this cycle; the other stop stays 0.
  - Next state is always IDLE.
- **Requester contract:**
  - A requester drops start on the edge that samples its stop high.
  - A start still high in the following IDLE cycle is a new transaction.
  - Address/data changes while a request is pending are ignored; values are latched at grant.
  - The arbiter ignores start of the non-granted port until IDLE; that request stays pending, so there is no starvation.
- **Outputs while not granted:** `*_mem_data_out` holds its last value.
- **Reset mid-transaction:** the FSM aborts to IDLE next edge. No stop is issued and `mem_we` is dropped. A partially written memory word is acceptable.

## Timing
- Start sampled high at edge k (FSM in IDLE) → `mem_*` valid from k+1 through k+`MEM_LATENCY`.
- Read data is latched at edge k+`MEM_LATENCY`.
- Stop is high during cycle k+`MEM_LATENCY`+1.
- Next grant is possible at edge k+`MEM_LATENCY`+2.
- Turnaround is `MEM_LATENCY`+2 cycles per transaction.
- Back-to-back contention alternates I, D, I, D…
- `MEM_LATENCY`=1: ACCESS lasts exactly one cycle.
- The counter never wraps: it is loaded only in IDLE and stops at 0.

## Structure
- **Package `mem_arb_pkg`:** `state_t` enum (IDLE, ACCESS, DONE); `port_t` (PORT_I=0, PORT_D=1); byte-lane count constant `LANES`=4.
- **Sub-module `rr_arbiter2`:** combinational two-request round-robin picker, inputs req[1:0] and `last_grant`, outputs grant_valid and grant_port. FSM, counter and datapath latches stay in `mem_arbiter`.

## Test plan
- **Single icache read, `MEM_LATENCY`=4:** `i_interupt_start`, addr 0x0000_0040, memory returns {0x11,0x22,0x33,0x44} → `mem_addr`=0x40 for cycles 1-4; `i_interupt_stop` high in cycle 5 only; `i_mem_data_out`={0x11,0x22,0x33,0x44}; `d_interupt_stop` stays 0.
- **Dcache write:** addr 0x0000_1000, data {0xDE,0xAD,0xBE,0xEF} → `mem_we`=1 for exactly 4 cycles with those bytes; `d_interupt_stop` pulses; `d_mem_data_out` unchanged.
- **Simultaneous requests after reset:** both starts asserted together → icache granted first (stop at cycle 5), dcache granted at cycle 6 (stop at cycle 11). Continuous re-requests alternate grants I, D, I, D.
- **Late arrival:** `d_interupt_start` rises during an icache ACCESS → ignored until IDLE, then served. Dcache address changes mid-wait → the value at grant is used.
- **Reset mid-ACCESS:** reset asserted on cycle 2 of a write → next cycle `mem_we`=0, state IDLE, no stop pulse. After reset releases, a held start is served normally with icache priority.
- **`MEM_LATENCY`=1 build:** read completes with stop at cycle 2 and 3-cycle turnaround.
